// File: rtl/if_prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue.
package if_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} pf_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_prefetch_queue_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd, wr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop)  rd <= rd + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; empty gating keeps stale words invisible.
  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr] <= din;
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Sequential instruction prefetcher: credit-limited SRAM fetch, FIFO of {pc, instr}, redirect flush.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [13:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;

  pf_state_t    state, state_nxt;
  logic [31:0]  fetch_pc, resp_pc, target;
  logic [OW-1:0] outstanding, out_nxt, discard, disc_nxt;
  logic [CW-1:0] count;
  logic         full, empty, push, pop, accept;
  fetch_entry_t head, entry;

  assign target   = redirect_pc & 32'hFFFF_FFFC;
  assign mem_addr = fetch_pc[15:2];
  // Queue slots are reserved at request time so a returning word always fits.
  assign mem_req  = (state != BOOT) && !redirect
                 && (32'(count) + 32'(outstanding) < 32'(DEPTH))
                 && (32'(outstanding) < 32'(MAX_OUT));
  assign accept   = mem_req && mem_gnt;
  assign push     = mem_rvalid && (discard == '0) && !redirect;
  assign pop      = f_valid && f_ready && !redirect;
  assign out_nxt  = outstanding + OW'(accept) - OW'(mem_rvalid);
  assign entry    = '{pc: resp_pc, instr: mem_rdata};

  assign f_valid  = !empty;
  assign f_pc     = head.pc;
  assign f_instr  = head.instr;

  always_comb begin
    disc_nxt  = discard;
    state_nxt = state;
    if (redirect)
      disc_nxt = out_nxt;
    else if (mem_rvalid && discard != '0)
      disc_nxt = discard - OW'(1);
    case (state)
      BOOT:    state_nxt = RUN;
      DRAIN:   if (disc_nxt == '0) state_nxt = RUN;
      default: state_nxt = state;
    endcase
    if (redirect) state_nxt = (disc_nxt != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      discard     <= disc_nxt;
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push)   resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && full && !pop));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized scoreboard bench: a sequential-PC program model plus an in-order SRAM model.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;

  logic        clk = 0;
  logic        rst, f_valid, f_ready, redirect, mem_req, mem_gnt, mem_rvalid;
  logic [31:0] f_pc, f_instr, redirect_pc, mem_rdata;
  logic [13:0] mem_addr;

  if_prefetch_queue dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc),
    .f_instr(f_instr), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] data; int due; bit stale; } rsp_t;

  exp_t        exp_q[$];      // program-order words still owed to IF (queued + kept in flight)
  rsp_t        pend_q[$];     // memory responses not yet returned
  logic [31:0] exp_pc;
  int          cyc = 0, last_due = 0, lat_max = 1;
  int          p_gnt = 100, p_ready = 100;
  int          total = 0, passed = 0;
  bit          boot = 0;

  function automatic logic [31:0] memfn(input logic [13:0] a);
    return {a, 2'b01, ~a, 2'b10};
  endfunction

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
  endtask

  // Monitor: outputs and handshakes are stable at the falling edge.
  always @(negedge clk) begin
    int kept, queued;
    bit req_exp;
    if (!rst) begin
      exp_q.delete(); pend_q.delete();
      exp_pc = 32'h0; last_due = 0; boot = 1;
    end else begin
      kept = 0;
      foreach (pend_q[i]) if (!pend_q[i].stale) kept++;
      queued = exp_q.size() - kept;
      if (boot) begin
        check("boot_f_pc", f_pc == 0, f_pc, 0);
        check("boot_f_instr", f_instr == 0, f_instr, 0);
      end
      req_exp = !boot && !redirect && (queued + pend_q.size() < DEPTH) && (pend_q.size() < MAX_OUT);
      check("mem_req", mem_req == req_exp, 32'(mem_req), 32'(req_exp));
      check("mem_addr", mem_addr == exp_pc[15:2], 32'(mem_addr), 32'(exp_pc[15:2]));
      check("f_valid", f_valid == (queued > 0), 32'(f_valid), 32'(queued > 0));
      if (f_valid && queued > 0) begin
        check("f_pc", f_pc == exp_q[0].pc, f_pc, exp_q[0].pc);
        check("f_instr", f_instr == exp_q[0].instr, f_instr, exp_q[0].instr);
        if (f_ready && !redirect) void'(exp_q.pop_front());
      end
      if (mem_rvalid) begin
        if (pend_q.size() == 0) check("bench_rvalid", 0, 1, 0);
        else void'(pend_q.pop_front());
      end
      if (mem_req && mem_gnt) begin
        rsp_t r;
        exp_q.push_back('{pc: exp_pc, instr: memfn(exp_pc[15:2])});
        r.data = memfn(mem_addr);
        r.due = (cyc + lat_max > last_due + 1) ? cyc + $urandom_range(lat_max, 1) : last_due + 1;
        if (r.due <= last_due) r.due = last_due + 1;
        r.stale = 0;
        last_due = r.due;
        pend_q.push_back(r);
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
        exp_q.delete();
        foreach (pend_q[i]) pend_q[i].stale = 1;
        exp_pc = {redirect_pc[31:2], 2'b00};
      end
      boot = 0;
    end
  end

  task automatic step(input bit rn, input bit redir, input logic [31:0] tgt);
    @(posedge clk); #1;
    cyc++;
    rst = rn;
    redirect = redir && rn;
    redirect_pc = tgt;
    mem_gnt = ($urandom_range(99) < p_gnt);
    f_ready = ($urandom_range(99) < p_ready);
    if (rn && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_rvalid = 1; mem_rdata = pend_q[0].data;
    end else begin
      mem_rvalid = 0; mem_rdata = $urandom;
    end
  endtask

  initial begin
    rst = 0; redirect = 0; redirect_pc = 0; mem_gnt = 0; f_ready = 0;
    mem_rvalid = 0; mem_rdata = 0;
    repeat (2) step(0, 0, 0);
    // Streaming: always granted, single-cycle latency.
    repeat (30) step(1, 0, 0);
    // IF stall fills the queue, then drains in order.
    p_ready = 0;
    repeat (10) step(1, 0, 0);
    p_ready = 100;
    repeat (8) step(1, 0, 0);
    // Redirect with responses in flight.
    lat_max = 3;
    repeat (3) step(1, 0, 0);
    step(1, 1, 32'h0000_0102);
    repeat (10) step(1, 0, 0);
    // Grant withheld: address must hold.
    p_gnt = 0;
    repeat (5) step(1, 0, 0);
    p_gnt = 100;
    repeat (5) step(1, 0, 0);
    // Randomized traffic including wrap-around targets.
    p_gnt = 70; p_ready = 70;
    for (int i = 0; i < 3000; i++)
      step(1, $urandom_range(99) < 6,
           ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
    // Reset with a full queue.
    p_gnt = 100; p_ready = 0; lat_max = 1;
    repeat (12) step(1, 0, 0);
    step(0, 0, 0);
    p_ready = 100;
    repeat (20) step(1, 0, 0);
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
